// File: rtl/assoc_mem_score_tally.sv
// Associative-memory scoring stage: per-class overlap accumulation, argmax inference and accuracy tally.
// Optional macro ASSOC_MEM_MARGIN_EN adds pred_margin/low_conf confidence outputs.
module assoc_mem_score_tally #(
  parameter int unsigned NUM_CLASSES     = 26,
  parameter int unsigned SEG_WIDTH       = 128,
  parameter int unsigned SEQ_CYCLE_COUNT = 10,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned SCORE_W = $clog2(SEG_WIDTH*SEQ_CYCLE_COUNT+1),
  localparam int unsigned CLS_W   = $clog2(NUM_CLASSES)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic                             comparing_query_hv_with_class_hv,
  input  logic                             inferring_class,
  input  logic                             tallying_accuracy,
  input  logic [3:0]                       query_ctr,
  input  logic [SEG_WIDTH-1:0]             query_seg,
  input  logic [NUM_CLASSES*SEG_WIDTH-1:0] class_segs,
  input  logic [CLS_W-1:0]                 true_label,
  input  logic                             clear_tally,
  output logic [CLS_W-1:0]                 predicted_class,
  output logic                             pred_valid,
  output logic [CNT_W-1:0]                 correct_count,
`ifdef ASSOC_MEM_MARGIN_EN
  output logic [SCORE_W-1:0]               pred_margin,
  output logic                             low_conf,
`endif
  output logic [CNT_W-1:0]                 total_count
);

  localparam logic [3:0] SEQ_CNT4 = 4'(SEQ_CYCLE_COUNT);

  logic [SCORE_W-1:0] score_q [NUM_CLASSES];
  logic [SCORE_W-1:0] score_d [NUM_CLASSES];
  logic [SCORE_W-1:0] ov      [NUM_CLASSES];
  logic [CLS_W-1:0]   pred_q, pred_d;
  logic               pred_valid_q, pred_valid_d;
  logic [CNT_W-1:0]   correct_q, correct_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CLS_W-1:0]   best_idx;
  logic [SCORE_W-1:0] best_sc;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      ov[c] = '0;
      for (int unsigned b = 0; b < SEG_WIDTH; b++)
        ov[c] = ov[c] + SCORE_W'(query_seg[b] & class_segs[c*SEG_WIDTH+b]);
    end
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_sc  = score_q[0];
    for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
      if (score_q[c] > best_sc) begin
        best_sc  = score_q[c];
        best_idx = CLS_W'(c);
      end
    end
  end

`ifdef ASSOC_MEM_MARGIN_EN
  logic [SCORE_W-1:0] second_sc, margin_d, margin_q;
  logic               low_conf_d, low_conf_q;

  // Any other class equal to the best yields a zero margin.
  always_comb begin
    second_sc = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      if (CLS_W'(c) != best_idx && score_q[c] > second_sc)
        second_sc = score_q[c];
    end
  end

  always_comb begin
    margin_d   = margin_q;
    low_conf_d = low_conf_q;
    if (en && !comparing_query_hv_with_class_hv && inferring_class) begin
      margin_d   = best_sc - second_sc;
      low_conf_d = (best_sc - second_sc) < SCORE_W'(8);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      margin_q   <= '0;
      low_conf_q <= 1'b0;
    end else begin
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
    end
  end

  assign pred_margin = margin_q;
  assign low_conf    = low_conf_q;
`endif

  always_comb begin
    score_d      = score_q;
    pred_d       = pred_q;
    pred_valid_d = 1'b0;
    correct_d    = correct_q;
    total_d      = total_q;
    if (en) begin
      if (comparing_query_hv_with_class_hv) begin
        if (query_ctr < SEQ_CNT4) begin
          for (int unsigned c = 0; c < NUM_CLASSES; c++)
            score_d[c] = (query_ctr == '0) ? ov[c] : score_q[c] + ov[c];
        end
      end else if (inferring_class) begin
        pred_d       = best_idx;
        pred_valid_d = 1'b1;
      end else if (tallying_accuracy) begin
        if (total_q != '1)
          total_d = total_q + CNT_W'(1);
        if (pred_q == true_label && correct_q != '1)
          correct_d = correct_q + CNT_W'(1);
      end
      if (clear_tally) begin
        correct_d = '0;
        total_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++)
        score_q[c] <= '0;
      pred_q       <= '0;
      pred_valid_q <= 1'b0;
      correct_q    <= '0;
      total_q      <= '0;
    end else begin
      score_q      <= score_d;
      pred_q       <= pred_d;
      pred_valid_q <= pred_valid_d;
      correct_q    <= correct_d;
      total_q      <= total_d;
    end
  end

  assign predicted_class = pred_q;
  assign pred_valid      = pred_valid_q;
  assign correct_count   = correct_q;
  assign total_count     = total_q;

endmodule

// File: tb/tb_assoc_mem_score_tally.sv
// Bench for assoc_mem_score_tally: directed scenarios plus random queries against a behavioural model.
// Define ASSOC_MEM_MARGIN_EN to also check pred_margin/low_conf.
module tb_assoc_mem_score_tally;
  localparam int NC = 26, SW = 128, SC = 10;

  logic clk = 1'b0;
  logic nrst, en, cmp, inf, tal, clr;
  logic [3:0]       qc;
  logic [SW-1:0]    qseg;
  logic [NC*SW-1:0] csegs;
  logic [4:0]       label;
  logic [4:0]       pred;
  logic             pv;
  logic [15:0]      corr, tot;
`ifdef ASSOC_MEM_MARGIN_EN
  logic [10:0]      margin;
  logic             lowc;
`endif

  logic [SW-1:0] qhv [SC];
  logic [SW-1:0] chv [NC][SC];

  int n_checks = 0, n_fail = 0;

  int m_score [NC];
  int m_pred = 0, m_correct = 0, m_total = 0, m_margin = 0;
  bit m_pv = 0, m_low = 0;
  int srt [$];
  int ov;

  always #5 clk = ~clk;

  assoc_mem_score_tally #(.NUM_CLASSES(NC), .SEG_WIDTH(SW), .SEQ_CYCLE_COUNT(SC), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .en(en),
    .comparing_query_hv_with_class_hv(cmp), .inferring_class(inf), .tallying_accuracy(tal),
    .query_ctr(qc), .query_seg(qseg), .class_segs(csegs), .true_label(label), .clear_tally(clr),
    .predicted_class(pred), .pred_valid(pv), .correct_count(corr),
`ifdef ASSOC_MEM_MARGIN_EN
    .pred_margin(margin), .low_conf(lowc),
`endif
    .total_count(tot)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scores as plain integers, argmax/margin from a sorted copy.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      foreach (m_score[k]) m_score[k] = 0;
      m_pred = 0; m_pv = 0; m_correct = 0; m_total = 0; m_margin = 0; m_low = 0;
    end else if (en) begin
      m_pv = 0;
      if (cmp) begin
        if (qc < SC)
          for (int k = 0; k < NC; k++) begin
            ov = $countones(qseg & csegs[k*SW +: SW]);
            m_score[k] = (qc == 0) ? ov : m_score[k] + ov;
          end
      end else if (inf) begin
        srt = {};
        foreach (m_score[k]) srt.push_back(m_score[k]);
        srt.rsort();
        for (int k = NC-1; k >= 0; k--) if (m_score[k] == srt[0]) m_pred = k;
        m_margin = srt[0] - srt[1];
        m_low = (m_margin < 8);
        m_pv = 1;
      end else if (tal) begin
        if (m_total < 65535) m_total++;
        if (m_pred == int'(label) && m_correct < 65535) m_correct++;
      end
      if (clr) begin m_correct = 0; m_total = 0; end
    end else m_pv = 0;
  end

  always @(posedge clk) begin
    #1;
    chk("pred", pred, m_pred);
    chk("pred_valid", pv, m_pv);
    chk("correct", corr, m_correct);
    chk("total", tot, m_total);
`ifdef ASSOC_MEM_MARGIN_EN
    chk("margin", margin, m_margin);
    chk("low_conf", lowc, m_low);
`endif
  end

  function automatic int ref_score(int k);
    int t = 0;
    for (int s = 0; s < SC; s++) t += $countones(qhv[s] & chv[k][s]);
    return t;
  endfunction

  function automatic int ref_argmax();
    int b = 0;
    for (int k = 1; k < NC; k++) if (ref_score(k) > ref_score(b)) b = k;
    return b;
  endfunction

  function automatic logic [SW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_pattern(input logic [SW-1:0] q);
    for (int s = 0; s < SC; s++) begin
      qhv[s] = q;
      for (int k = 0; k < NC; k++) chv[k][s] = '0;
    end
  endtask

  task automatic drive(input bit c_v, input bit i_v, input bit t_v, input bit cl_v, input bit e_v, input int s);
    int si;
    @(negedge clk);
    si = (s < SC) ? s : 0;
    cmp = c_v; inf = i_v; tal = t_v; clr = cl_v; en = e_v;
    qc = 4'(s);
    qseg = qhv[si];
    for (int k = 0; k < NC; k++) csegs[k*SW +: SW] = chv[k][si];
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_query(input int lbl, input bit gaps);
    label = 5'(lbl);
    for (int s = 0; s < SC; s++) begin
      if (gaps)
        while ($urandom_range(0, 5) == 0)
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, s);
      drive(1, 0, 0, 0, 1, s);
    end
    drive(0, 1, 0, 0, 1, 0);
  endtask

  initial begin
    nrst = 1'b0; en = 0; cmp = 0; inf = 0; tal = 0; clr = 0;
    qc = '0; qseg = '0; csegs = '0; label = '0;
    foreach (m_score[k]) m_score[k] = 0;
    set_pattern('0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pred", pred, 0); chk("rst_pv", pv, 0);
    chk("rst_correct", corr, 0); chk("rst_total", tot, 0);
    @(negedge clk); nrst = 1'b1;

    // Query A: 4-bit query, class 3 all ones -> score 40.
    set_pattern(128'h0F);
    for (int s = 0; s < SC; s++) chv[3][s] = '1;
    run_query(3, 0);
    settle();
    chk("A_model_score3", m_score[3], 40);
    chk("A_pred", pred, 3); chk("A_pv", pv, 1);
    drive(0, 0, 1, 0, 1, 0); settle();
    chk("A_pv_drop", pv, 0); chk("A_correct", corr, 1); chk("A_total", tot, 1);

    // Query B: predicts 7, labelled 2 (back-to-back with no idle).
    set_pattern(128'h0F);
    for (int s = 0; s < SC; s++) chv[7][s] = '1;
    run_query(2, 0);
    settle(); chk("B_pred", pred, 7);
    drive(0, 0, 1, 0, 1, 0); settle();
    chk("B_correct", corr, 1); chk("B_total", tot, 2);

    // Tie between classes 5 and 9 at 640.
    set_pattern('1);
    for (int s = 0; s < SC; s++) begin
      chv[5][s] = {64'h0, {64{1'b1}}};
      chv[9][s] = {64'h0, {64{1'b1}}};
    end
    run_query(5, 0);
    settle();
    chk("tie_model_score9", m_score[9], 640);
    chk("tie_pred", pred, 5);
`ifdef ASSOC_MEM_MARGIN_EN
    chk("tie_margin", margin, 0); chk("tie_low", lowc, 1);
`endif
    drive(0, 0, 1, 0, 1, 0); settle();
    chk("tie_correct", corr, 2); chk("tie_total", tot, 3);

    // Best 40 vs second 35.
    set_pattern(128'h0F);
    for (int s = 0; s < SC; s++) begin
      chv[0][s] = '1;
      chv[1][s] = (s < 5) ? 128'h0F : 128'h07;
    end
    run_query(0, 0);
    settle(); chk("m1_pred", pred, 0);
`ifdef ASSOC_MEM_MARGIN_EN
    chk("m1_margin", margin, 5); chk("m1_low", lowc, 1);
`endif

    // Best 640, second 0.
    set_pattern('1);
    for (int s = 0; s < SC; s++) chv[5][s] = {64'h0, {64{1'b1}}};
    run_query(0, 0);
    settle(); chk("m2_pred", pred, 5);
`ifdef ASSOC_MEM_MARGIN_EN
    chk("m2_margin", margin, 640); chk("m2_low", lowc, 0);
`endif
    drive(0, 0, 0, 0, 1, 0);

    // en low for 3 cycles mid-compare, strobe still asserted.
    for (int s = 0; s < SC; s++) begin
      qhv[s] = rnd128() & rnd128();
      for (int k = 0; k < NC; k++) chv[k][s] = rnd128() & rnd128();
    end
    label = 5'(ref_argmax());
    for (int s = 0; s < SC; s++) begin
      if (s == 5) repeat (3) drive(1, 0, 0, 0, 0, s);
      drive(1, 0, 0, 0, 1, s);
    end
    drive(0, 1, 0, 0, 1, 0);
    settle();
    for (int k = 0; k < NC; k++) chk("freeze_score", m_score[k], ref_score(k));
    chk("freeze_pred", pred, ref_argmax());
    drive(0, 0, 1, 0, 1, 0);

    // Random queries with en gaps and junk strobes while disabled.
    for (int n = 0; n < 25; n++) begin
      for (int s = 0; s < SC; s++) begin
        qhv[s] = rnd128() & rnd128() & rnd128();
        for (int k = 0; k < NC; k++) chv[k][s] = rnd128() & rnd128();
      end
      run_query($urandom_range(0, 1) ? ref_argmax() : $urandom_range(0, NC-1), 1);
      drive(0, 0, 1, ($urandom_range(0, 9) == 0), 1, 0);
      if ($urandom_range(0, 2) == 0) drive(0, 0, 0, 0, 1, 0);
    end

    // Clear coincident with tally.
    run_query(ref_argmax(), 0);
    drive(0, 0, 1, 1, 1, 0); settle();
    chk("clr_correct", corr, 0); chk("clr_total", tot, 0);
    run_query(ref_argmax(), 0);
    drive(0, 0, 1, 0, 1, 0); settle();
    chk("post_clr_total", tot, 1); chk("post_clr_correct", corr, 1);

    // Async reset at query_ctr=4.
    for (int s = 0; s < 5; s++) drive(1, 0, 0, 0, 1, s);
    #2 nrst = 1'b0;
    #1;
    chk("arst_pred", pred, 0); chk("arst_pv", pv, 0);
    chk("arst_correct", corr, 0); chk("arst_total", tot, 0);
    @(negedge clk); nrst = 1'b1;

    // Saturation after 65535 correct tallies.
    label = 5'(ref_argmax());
    run_query(ref_argmax(), 0);
    drive(0, 0, 0, 1, 1, 0);
    repeat (65535) drive(0, 0, 1, 0, 1, 0);
    settle();
    chk("sat_total", tot, 65535); chk("sat_correct", corr, 65535);
    drive(0, 0, 1, 0, 1, 0); settle();
    chk("sat_total_hold", tot, 65535); chk("sat_correct_hold", corr, 65535);
    drive(0, 0, 0, 0, 1, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/assoc_mem_score_tally.md
Name: assoc_mem_score_tally

Overview:
Datapath stage consuming the associative-memory control strobes (comparing_query_hv_with_class_hv, inferring_class, tallying_accuracy, query_ctr).
- Compare phase: accumulates per-class overlap scores of the sparse query HV against all class HVs, one segment per cycle.
- Infer phase: picks the argmax class.
- Tally phase: updates running test-accuracy counters against the ground-truth label.
Sits directly downstream of the associative-memory FSM; feeds the accuracy readout/CSR block.

Parameters:
NUM_CLASSES, 26, number of class HVs.
SEG_WIDTH, 128, bits per HV segment compared per cycle.
SEQ_CYCLE_COUNT, 10, segments per HV; full HV = SEG_WIDTH*SEQ_CYCLE_COUNT bits.
CNT_W, 16, width of the correct and total tally counters.
Derived localparams:
- SCORE_W = $clog2(SEG_WIDTH*SEQ_CYCLE_COUNT+1), 11 at defaults.
- CLS_W = $clog2(NUM_CLASSES), 5 at defaults.

Ports:
clk  in  1  clock.
nrst  in  1  reset, asynchronous, active-low.
en  in  1  global enable; when low, all state holds.
comparing_query_hv_with_class_hv  in  1  compare-phase strobe.
inferring_class  in  1  infer-phase strobe (one cycle).
tallying_accuracy  in  1  tally-phase strobe (one cycle).
query_ctr  in  4  current segment index, 0..SEQ_CYCLE_COUNT-1.
query_seg  in  SEG_WIDTH  query HV segment selected by query_ctr.
class_segs  in  NUM_CLASSES*SEG_WIDTH  class HV segments, class c at bits [c*SEG_WIDTH +: SEG_WIDTH].
true_label  in  CLS_W  ground-truth class of the current query; stable from infer through tally.
clear_tally  in  1  synchronous clear of the tally counters.
predicted_class  out  CLS_W  registered argmax result.
pred_valid  out  1  one-cycle pulse, high in the cycle after the infer strobe.
correct_count  out  CNT_W  number of correct predictions.
total_count  out  CNT_W  number of tallied queries.

Behaviour:
- Reset (async): all scores, predicted_class, pred_valid, correct_count and total_count go to 0. Reset mid-query discards partial scores; no recovery is required.
- en=0: scores, prediction and counters hold; pred_valid goes to 0.
- Strobe priority when several are high at once (illegal; one-hot expected): compare > infer > tally. Only the winning strobe acts.
- Compare (strobe && en):
  - ov[c] = popcount(query_seg & class_segs[c]), range 0..SEG_WIDTH.
  - If query_ctr==0: score[c] <= ov[c], so no separate clear is needed.
  - Otherwise: score[c] <= score[c] + ov[c].
  - SCORE_W is sized so the sum never overflows.
  - query_ctr >= SEQ_CYCLE_COUNT: no update, scores hold.
- Infer (strobe && en):
  - Combinational argmax over score[0..NUM_CLASSES-1]; on ties the lowest index wins.
  - Argmax index is registered into predicted_class.
  - pred_valid=1 next cycle, then 0.
  - Scores are not modified.
- Tally (strobe && en):
  - total_count += 1.
  - correct_count += 1 if predicted_class == true_label, using the value registered in the infer cycle.
  - Both counters saturate at 2^CNT_W-1 independently; no wrap.
- clear_tally && en: both counters go to 0. If coincident with a tally strobe, clear wins and that query is not counted. Scores and prediction are unaffected.
- Latency:
  - Prediction visible 1 cycle after the infer strobe.
  - Counters update 1 cycle after the tally strobe.
  - A tally strobe immediately after infer (the FSM sequence) sees the new prediction.
- Back-to-back queries (tally directly followed by compare with query_ctr==0) need no idle cycle.

Optional Feature:
Macro ASSOC_MEM_MARGIN_EN.
- Defined:
  - Adds output pred_margin [SCORE_W-1:0], registered in the infer cycle as best score minus second-best score (0 on a tie).
  - Adds output low_conf [1]: 1 when pred_margin < 8.
  - Both reset to 0 and hold when en=0.
- Undefined: neither port exists and no second-best logic is synthesised.

Test Plan:
- Full query, 10 segments:
  - Stimulus: query_seg = 128'h0F (4 bits set); class 3 = all-ones; all other classes = 0.
  - Response after 10 compare cycles: score[3]=40, all others 0.
  - Infer: predicted_class=3, pred_valid pulses for 1 cycle.
- Tie-break: classes 5 and 9 end with equal score 640 -> predicted_class=5.
- Tally accounting:
  - true_label=3 after the case above: correct_count=1, total_count=1.
  - Next query predicts 7 with true_label=2: correct_count=1, total_count=2.
- Saturation and clear:
  - Preload 65535 tallies with CNT_W=16: total_count stays at 65535 on the next tally.
  - clear_tally coincident with a tally strobe: both counters read 0.
- en and reset:
  - en=0 for 3 cycles mid-compare: scores frozen, final scores equal the uninterrupted run.
  - nrst asserted at query_ctr=4: all outputs 0 immediately, without waiting for a clock edge.
- ASSOC_MEM_MARGIN_EN:
  - Best=40, second=35 -> pred_margin=5, low_conf=1.
  - Best=640, second=0 -> pred_margin=640, low_conf=0.
